// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: controller state encoding
// and the supported oversampling ratios.
package uart_rx_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      START  = ST_START,
      DATA   = ST_DATA,
      PARITY = ST_PARITY,
      STOP   = ST_STOP
   } rx_state_e;

   localparam int PRESCALE_8  = 8;
   localparam int PRESCALE_16 = 16;
   localparam int PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Bundle between the RX sequencer (master) and the pin/datapath side (slave).
interface uart_rx_ctrl_if #(
   parameter int PRESCALE_WIDTH = 6,
   parameter int DATA_WIDTH     = 8
);
   localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic                      RX_IN;
   logic                      PAR_EN;
   logic [PRESCALE_WIDTH-1:0] Prescale;
   logic                      sampled_bit;
   logic                      par_err;
   logic                      stp_err;
   logic                      dat_samp_en;
   logic [PRESCALE_WIDTH-1:0] edge_cnt;
   logic [BIT_W-1:0]          bit_cnt;
   logic                      deser_en;
   logic                      par_chk_en;
   logic                      stp_chk_en;
   logic                      data_valid;
   logic                      frame_err;

   modport master (
      input  RX_IN, PAR_EN, Prescale, sampled_bit, par_err, stp_err,
      output dat_samp_en, edge_cnt, bit_cnt, deser_en, par_chk_en, stp_chk_en,
             data_valid, frame_err
   );

   modport slave (
      output RX_IN, PAR_EN, Prescale, sampled_bit, par_err, stp_err,
      input  dat_samp_en, edge_cnt, bit_cnt, deser_en, par_chk_en, stp_chk_en,
             data_valid, frame_err
   );

endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter (wraps at last_edge) and data-bit counter that
// advances on each edge wrap while enabled.
module uart_rx_edge_bit_cnt #(
   parameter int PRESCALE_WIDTH = 6,
   parameter int DATA_WIDTH     = 8,
   parameter int BIT_W          = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clr,
   input  logic                      bit_en,
   input  logic [PRESCALE_WIDTH-1:0] last_edge,
   output logic [PRESCALE_WIDTH-1:0] edge_cnt,
   output logic [BIT_W-1:0]          bit_cnt,
   output logic                      edge_wrap,
   output logic                      bit_last
);
   localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_WIDTH - 1);

   assign edge_wrap = (edge_cnt == last_edge);
   assign bit_last  = (bit_cnt == BIT_MAX);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         edge_cnt <= edge_wrap ? '0 : edge_cnt + 1'b1;
         if (bit_en && edge_wrap)
            bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: walks START/DATA/PARITY/STOP on oversample edges,
// strobes the datapath at mid-bit and reports each frame's outcome.
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE_WIDTH = 6,
   parameter int DATA_WIDTH     = 8
) (
   input  logic           clk,
   input  logic           reset,
   uart_rx_ctrl_if.master bus
);
   localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   rx_state_e                 state, state_nxt;
   logic [PRESCALE_WIDTH-1:0] presc_lat;
   logic [PRESCALE_WIDTH-1:0] edge_cnt;
   logic [BIT_W-1:0]          bit_cnt;
   logic                      par_en_lat, err_flag, data_valid, frame_err;
   logic                      edge_wrap, bit_last, at_mid, cnt_clr;
   logic                      samp_en, deser_en, par_chk_en, stp_chk_en;

   assign at_mid  = (edge_cnt == (presc_lat >> 1));
   // Counters restart on every return to IDLE, including a rejected start bit.
   assign cnt_clr = (state == IDLE) || (state_nxt == IDLE);

   uart_rx_edge_bit_cnt #(
      .PRESCALE_WIDTH (PRESCALE_WIDTH),
      .DATA_WIDTH     (DATA_WIDTH),
      .BIT_W          (BIT_W)
   ) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .clr       (cnt_clr),
      .bit_en    (state == DATA),
      .last_edge (presc_lat - 1'b1),
      .edge_cnt  (edge_cnt),
      .bit_cnt   (bit_cnt),
      .edge_wrap (edge_wrap),
      .bit_last  (bit_last)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      samp_en    = 1'b0;
      deser_en   = 1'b0;
      par_chk_en = 1'b0;
      stp_chk_en = 1'b0;
      case (state)
         IDLE: begin
            if (!bus.RX_IN) state_nxt = START;
         end
         START: begin
            samp_en = 1'b1;
            if (at_mid && bus.sampled_bit) state_nxt = IDLE;
            else if (edge_wrap)            state_nxt = DATA;
         end
         DATA: begin
            samp_en  = 1'b1;
            deser_en = at_mid;
            if (edge_wrap && bit_last) state_nxt = par_en_lat ? PARITY : STOP;
         end
         PARITY: begin
            samp_en    = 1'b1;
            par_chk_en = at_mid;
            if (edge_wrap) state_nxt = STOP;
         end
         STOP: begin
            samp_en    = 1'b1;
            stp_chk_en = at_mid;
            if (edge_wrap) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_lat  <= PRESCALE_WIDTH'(PRESCALE_8);
         par_en_lat <= 1'b0;
         err_flag   <= 1'b0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (state == IDLE && !bus.RX_IN) begin
            presc_lat  <= bus.Prescale;
            par_en_lat <= bus.PAR_EN;
            err_flag   <= 1'b0;
         end
         if (state == PARITY && edge_wrap)
            err_flag <= err_flag | bus.par_err;
         if (state == STOP && edge_wrap) begin
            data_valid <= ~(err_flag | bus.stp_err);
            frame_err  <= err_flag | bus.stp_err;
         end
      end
   end

   assign bus.dat_samp_en = samp_en;
   assign bus.edge_cnt    = edge_cnt;
   assign bus.bit_cnt     = bit_cnt;
   assign bus.deser_en    = deser_en;
   assign bus.par_chk_en  = par_chk_en;
   assign bus.stp_chk_en  = stp_chk_en;
   assign bus.data_valid  = data_valid;
   assign bus.frame_err   = frame_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: frame-level timing model checked every cycle, plus
// hand-computed expectations for the directed scenarios.
module tb_uart_rx_ctrl;
   localparam int PW = 6;
   localparam int DW = 8;

   typedef struct {
      string name;
      int    act;
      int    exp;
   } lit_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   lit_t lq[$];
   lit_t cur;

   // Frame model: cycle the line dropped, latched ratio/parity, last in-frame
   // cycle and the cycle carrying the result pulse.
   int m_t0 = -1000, m_p = 8, m_end = -1, m_pulse = -1;
   bit m_pe = 1'b0, m_dv = 1'b0;

   // Per-frame observations, relative to m_t0.
   int o_deser, o_dmin, o_dmax, o_pc, o_pc_rel, o_dv, o_dv_rel, o_fe, o_fe_rel, o_dse_last, o_strb;

   int   c_pos, c_bi, c_e;
   logic e_dse, e_deser, e_pc, e_sc, e_dv, e_fe;
   logic [PW-1:0] e_edge;
   logic [2:0]    e_bit;
   logic [14:0]   act_v, exp_v;

   uart_rx_ctrl_if #(.PRESCALE_WIDTH(PW), .DATA_WIDTH(DW)) bus ();

   uart_rx_ctrl #(.PRESCALE_WIDTH(PW), .DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cyc >= 1) begin
         e_dse = 0; e_edge = '0; e_bit = '0; e_deser = 0; e_pc = 0; e_sc = 0; e_dv = 0; e_fe = 0;
         if (cyc > m_t0 && cyc <= m_end) begin
            c_pos = cyc - m_t0 - 1;
            c_bi  = c_pos / m_p;
            c_e   = c_pos % m_p;
            e_dse  = 1'b1;
            e_edge = PW'(c_e);
            if (c_bi >= 1 && c_bi <= DW) begin
               e_bit   = 3'(c_bi - 1);
               e_deser = (c_e == m_p / 2);
            end
            if (m_pe && c_bi == DW + 1) e_pc = (c_e == m_p / 2);
            if (c_bi == DW + 1 + int'(m_pe)) e_sc = (c_e == m_p / 2);
         end
         if (cyc == m_pulse) begin
            e_dv = m_dv;
            e_fe = !m_dv;
         end
         act_v = {bus.dat_samp_en, bus.edge_cnt, bus.bit_cnt, bus.deser_en, bus.par_chk_en,
                  bus.stp_chk_en, bus.data_valid, bus.frame_err};
         exp_v = {e_dse, e_edge, e_bit, e_deser, e_pc, e_sc, e_dv, e_fe};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL cycle_model @%0d: got dse/edge/bit/deser/pc/sc/dv/fe=%b expected %b",
                     cyc, act_v, exp_v);
         end

         if (cyc == m_t0 + 1) begin
            o_deser = 0; o_dmin = 99; o_dmax = -1; o_pc = 0; o_pc_rel = -1; o_dv = 0;
            o_dv_rel = -1; o_fe = 0; o_fe_rel = -1; o_dse_last = -1; o_strb = 0;
         end
         if (bus.deser_en === 1'b1) begin
            o_deser++;
            if (int'(bus.edge_cnt) < o_dmin) o_dmin = int'(bus.edge_cnt);
            if (int'(bus.edge_cnt) > o_dmax) o_dmax = int'(bus.edge_cnt);
         end
         if (bus.par_chk_en === 1'b1) begin
            o_pc++;
            if (o_pc_rel < 0) o_pc_rel = cyc - m_t0;
         end
         if (bus.deser_en === 1'b1 || bus.par_chk_en === 1'b1 || bus.stp_chk_en === 1'b1) o_strb++;
         if (bus.data_valid === 1'b1) begin o_dv++; o_dv_rel = cyc - m_t0; end
         if (bus.frame_err === 1'b1) begin o_fe++; o_fe_rel = cyc - m_t0; end
         if (bus.dat_samp_en === 1'b1) o_dse_last = cyc - m_t0;
      end

      while (lq.size() > 0) begin
         cur = lq.pop_front();
         checks++;
         if (cur.act != cur.exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", cur.name, cur.act, cur.exp);
         end
      end
   end

   task automatic expect_eq(input string name, input int act, input int exp);
      lit_t l;
      l.name = name;
      l.act  = act;
      l.exp  = exp;
      lq.push_back(l);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   // Drives one serial frame; line drops in the first driven cycle. stop_k cuts
   // the frame short, chg_k scrambles Prescale/PAR_EN mid-frame.
   task automatic send_frame(input int p, input bit pe, input logic [7:0] d, input bit perr,
                             input bit serr, input int stop_k, input int chg_k);
      int   len, last_k, bi;
      logic line;
      len    = (2 + DW + int'(pe)) * p;
      last_k = (stop_k < 0) ? len : stop_k;
      for (int k = 0; k <= last_k; k++) begin
         @(negedge clk);
         #1;
         if (k == 0) begin
            bus.Prescale = PW'(p);
            bus.PAR_EN   = pe;
            bus.par_err  = perr;
            bus.stp_err  = serr;
            m_p     = p;
            m_pe    = pe;
            m_end   = cyc + len;
            m_pulse = cyc + len + 1;
            m_dv    = !((pe && perr) || serr);
            m_t0    = cyc;
         end
         if (k == chg_k) begin
            bus.Prescale = PW'(8);
            bus.PAR_EN   = !pe;
         end
         bi = k / p;
         if (bi == 0)                     line = 1'b0;
         else if (bi <= DW)               line = d[bi-1];
         else if (pe && bi == DW + 1)     line = ^d;
         else                             line = 1'b1;
         bus.RX_IN       = line;
         bus.sampled_bit = line;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.RX_IN = 1'b1; bus.PAR_EN = 1'b0; bus.Prescale = PW'(8);
      bus.sampled_bit = 1'b1; bus.par_err = 1'b0; bus.stp_err = 1'b0;
      reset = 1'b1;
      idle(3);
      reset = 1'b0;
      expect_eq("reset_dat_samp_en", int'(bus.dat_samp_en), 0);
      expect_eq("reset_edge_cnt", int'(bus.edge_cnt), 0);
      expect_eq("reset_data_valid", int'(bus.data_valid), 0);
      idle(3);

      // Clean frame, P=8, no parity
      send_frame(8, 1'b0, 8'hA5, 1'b0, 1'b0, -1, -1);
      idle(2);
      expect_eq("clean_deser_count", o_deser, 8);
      expect_eq("clean_deser_edge_min", o_dmin, 4);
      expect_eq("clean_deser_edge_max", o_dmax, 4);
      expect_eq("clean_dv_cycle", o_dv_rel, 81);
      expect_eq("clean_frame_err", o_fe, 0);
      idle(4);

      // Parity frame, P=16
      send_frame(16, 1'b1, 8'h3C, 1'b0, 1'b0, -1, -1);
      idle(2);
      expect_eq("par_chk_cycle", o_pc_rel, 153);
      expect_eq("par_chk_count", o_pc, 1);
      expect_eq("par_dv_cycle", o_dv_rel, 177);
      idle(4);

      // Start-bit glitch: line low for 3 cycles
      @(negedge clk); #1;
      bus.Prescale = PW'(8); bus.PAR_EN = 1'b0;
      bus.RX_IN = 1'b0; bus.sampled_bit = 1'b0;
      m_p = 8; m_pe = 1'b0; m_end = cyc + 5; m_pulse = -1; m_t0 = cyc;
      idle(2);
      bus.RX_IN = 1'b1; bus.sampled_bit = 1'b1;
      idle(12);
      expect_eq("glitch_last_samp_en", o_dse_last, 5);
      expect_eq("glitch_strobes", o_strb, 0);
      expect_eq("glitch_data_valid", o_dv, 0);
      expect_eq("glitch_frame_err", o_fe, 0);

      // Stop error, then an error-free frame
      send_frame(8, 1'b0, 8'h0F, 1'b0, 1'b1, -1, -1);
      idle(2);
      expect_eq("stperr_fe_cycle", o_fe_rel, 81);
      expect_eq("stperr_data_valid", o_dv, 0);
      idle(3);
      send_frame(8, 1'b0, 8'hF0, 1'b0, 1'b0, -1, -1);
      idle(2);
      expect_eq("after_stperr_dv_cycle", o_dv_rel, 81);
      expect_eq("after_stperr_frame_err", o_fe, 0);
      idle(3);

      // Parity error, then back-to-back clean parity frame and clean frame
      send_frame(8, 1'b1, 8'h81, 1'b1, 1'b0, -1, -1);
      idle(2);
      expect_eq("parerr_fe_cycle", o_fe_rel, 89);
      expect_eq("parerr_data_valid", o_dv, 0);
      idle(3);
      send_frame(8, 1'b1, 8'h55, 1'b0, 1'b0, -1, -1);
      send_frame(8, 1'b0, 8'hAA, 1'b0, 1'b0, -1, -1);
      idle(2);
      expect_eq("b2b_second_dv_cycle", o_dv_rel, 81);
      expect_eq("b2b_second_deser_count", o_deser, 8);
      idle(3);

      // Reset in the middle of data bit 2
      send_frame(8, 1'b0, 8'h5A, 1'b0, 1'b0, 30, -1);
      @(negedge clk); #1;
      reset = 1'b1; bus.RX_IN = 1'b1; bus.sampled_bit = 1'b1;
      m_end = cyc; m_pulse = -1;
      @(negedge clk); #1;
      reset = 1'b0;
      expect_eq("midreset_dat_samp_en", int'(bus.dat_samp_en), 0);
      expect_eq("midreset_edge_cnt", int'(bus.edge_cnt), 0);
      expect_eq("midreset_bit_cnt", int'(bus.bit_cnt), 0);
      expect_eq("midreset_deser_en", int'(bus.deser_en), 0);
      idle(4);

      // Prescale 32 changed to 8 mid-frame
      send_frame(32, 1'b0, 8'hC3, 1'b0, 1'b0, -1, 50);
      idle(2);
      expect_eq("presc_chg_dv_cycle", o_dv_rel, 321);
      expect_eq("presc_chg_deser_count", o_deser, 8);
      expect_eq("presc_chg_deser_edge", o_dmin, 16);
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
